// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V control unit: Moore FSM that sequences each instruction and
// decodes datapath selects, write enables and the ALU control code from the current state.
module multicycle_ctrl #(
   parameter int STATE_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [6:0]             opcode_i,
   input  logic [2:0]             funct3_i,
   input  logic                   funct7_5_i,
   input  logic                   zero_i,
   output logic                   pc_write_o,
   output logic                   adr_src_o,
   output logic                   ir_write_o,
   output logic                   mem_write_o,
   output logic                   reg_write_o,
   output logic [1:0]             result_src_o,
   output logic [1:0]             alu_src_a_o,
   output logic [1:0]             alu_src_b_o,
   output logic [2:0]             alu_ctrl_o,
   output logic                   illegal_o,
   output logic [STATE_WIDTH-1:0] state_o
);

   typedef enum logic [STATE_WIDTH-1:0] {
      S_FETCH    = STATE_WIDTH'(0),
      S_DECODE   = STATE_WIDTH'(1),
      S_MEMADR   = STATE_WIDTH'(2),
      S_MEMREAD  = STATE_WIDTH'(3),
      S_MEMWB    = STATE_WIDTH'(4),
      S_MEMWRITE = STATE_WIDTH'(5),
      S_EXECR    = STATE_WIDTH'(6),
      S_EXECI    = STATE_WIDTH'(7),
      S_ALUWB    = STATE_WIDTH'(8),
      S_BRANCH   = STATE_WIDTH'(9),
      S_JAL      = STATE_WIDTH'(10)
   } state_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_OR    = 3'd3;
   localparam logic [2:0] ALU_SLT   = 3'd4;
   localparam logic [2:0] ALU_SHL   = 3'd5;

   state_t state_q, state_d;

   // funct7_5 only selects SUB for register-register ops; addi's immediate bit 30 is data.
   function automatic logic [2:0] funct_alu(input logic is_r, input logic [2:0] f3,
                                            input logic f7_5);
      case (f3)
         3'b000:  funct_alu = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  funct_alu = ALU_SHL;
         3'b010:  funct_alu = ALU_SLT;
         3'b110:  funct_alu = ALU_OR;
         3'b111:  funct_alu = ALU_AND;
         default: funct_alu = ALU_ADD;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (opcode_i)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECR;
               OP_ITYPE:     state_d = S_EXECI;
               OP_BRANCH:    state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (opcode_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
         default:   state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_write_o   = 1'b0;
      adr_src_o    = 1'b0;
      ir_write_o   = 1'b0;
      mem_write_o  = 1'b0;
      reg_write_o  = 1'b0;
      result_src_o = 2'b00;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b00;
      alu_ctrl_o   = ALU_ADD;
      illegal_o    = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write_o   = 1'b1;
            pc_write_o   = 1'b1;
            alu_src_b_o  = 2'b10;
            result_src_o = 2'b10;
         end
         S_DECODE: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            case (opcode_i)
               OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: illegal_o = 1'b0;
               default: illegal_o = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
         end
         S_MEMREAD: adr_src_o = 1'b1;
         S_MEMWB: begin
            result_src_o = 2'b01;
            reg_write_o  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src_o   = 1'b1;
            mem_write_o = 1'b1;
         end
         S_EXECR: begin
            alu_src_a_o = 2'b10;
            alu_ctrl_o  = funct_alu(1'b1, funct3_i, funct7_5_i);
         end
         S_EXECI: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
            alu_ctrl_o  = funct_alu(1'b0, funct3_i, funct7_5_i);
         end
         S_ALUWB: reg_write_o = 1'b1;
         S_BRANCH: begin
            alu_src_a_o = 2'b10;
            alu_ctrl_o  = ALU_SUB;
            pc_write_o  = zero_i ^ funct3_i[0];
         end
         S_JAL: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
            pc_write_o  = 1'b1;
         end
         default: ;
      endcase
      // State already reads FETCH under reset; only the side-effecting strobes need masking.
      if (rst) begin
         pc_write_o  = 1'b0;
         ir_write_o  = 1'b0;
         mem_write_o = 1'b0;
         reg_write_o = 1'b0;
         illegal_o   = 1'b0;
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected output records are queued per instruction
// and compared against the DUT on each falling edge.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'b0;
   logic [2:0] funct3 = 3'b0;
   logic       f7_5 = 1'b0;
   logic       zero = 1'b0;
   logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
   logic [1:0] result_src, src_a, src_b;
   logic [2:0] alu_ctrl;
   logic [3:0] state;

   int n_chk  = 0;
   int n_fail = 0;
   logic [18:0] sbq[$];
   logic [18:0] exp_r;
   logic [18:0] obs;

   multicycle_ctrl #(.STATE_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .opcode_i(opcode), .funct3_i(funct3), .funct7_5_i(f7_5),
      .zero_i(zero), .pc_write_o(pc_write), .adr_src_o(adr_src), .ir_write_o(ir_write),
      .mem_write_o(mem_write), .reg_write_o(reg_write), .result_src_o(result_src),
      .alu_src_a_o(src_a), .alu_src_b_o(src_b), .alu_ctrl_o(alu_ctrl),
      .illegal_o(illegal), .state_o(state)
   );

   always #5 clk = ~clk;

   assign obs = {state, pc_write, adr_src, ir_write, mem_write, reg_write,
                 result_src, src_a, src_b, alu_ctrl, illegal};

   // Packs one cycle's expected outputs in the same field order as obs.
   function automatic logic [18:0] rec(input logic [3:0] st, input logic pcw, input logic adr,
                                       input logic irw, input logic mw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sbv, input logic [2:0] alu,
                                       input logic ill);
      rec = {st, pcw, adr, irw, mw, rw, rs, sa, sbv, alu, ill};
   endfunction

   function automatic logic [18:0] r_fetch();  return rec(0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, 3'd0, 0); endfunction
   function automatic logic [18:0] r_decode(); return rec(1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'd0, 0); endfunction
   function automatic logic [18:0] r_inrst();  return rec(0, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'd0, 0); endfunction
   function automatic logic [18:0] r_aluwb();  return rec(8, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'd0, 0); endfunction

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z);
      opcode = op; funct3 = f3; f7_5 = f7; zero = z;
   endtask

   task automatic test_reset();
      set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_chk++;
         if (obs !== r_inrst()) begin
            n_fail++;
            $display("FAIL reset cyc%0d: got %h required %h", i, obs, r_inrst());
         end
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_lw();
      set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      sbq.push_back(r_fetch());
      sbq.push_back(r_decode());
      sbq.push_back(rec(2, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd0, 0));
      sbq.push_back(rec(3, 0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'd0, 0));
      sbq.push_back(rec(4, 0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'd0, 0));
      for (int i = 0; sbq.size() != 0; i++) begin
         @(negedge clk);
         exp_r = sbq.pop_front();
         n_chk++;
         if (obs !== exp_r) begin
            n_fail++;
            $display("FAIL lw cyc%0d: got %h required %h", i, obs, exp_r);
         end
      end
   endtask

   task automatic test_sw_reset();
      set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      sbq.push_back(r_fetch());
      sbq.push_back(r_decode());
      sbq.push_back(rec(2, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd0, 0));
      sbq.push_back(rec(5, 0,1,0,1,0, 2'b00, 2'b00, 2'b00, 3'd0, 0));
      for (int i = 0; sbq.size() != 0; i++) begin
         @(negedge clk);
         exp_r = sbq.pop_front();
         n_chk++;
         if (obs !== exp_r) begin
            n_fail++;
            $display("FAIL sw cyc%0d: got %h required %h", i, obs, exp_r);
         end
      end
      rst = 1'b1;
      #1;
      n_chk++;
      if (obs !== r_inrst()) begin
         n_fail++;
         $display("FAIL sw_midreset: got %h required %h", obs, r_inrst());
      end
      @(posedge clk); #1;
      n_chk++;
      if (obs !== r_inrst()) begin
         n_fail++;
         $display("FAIL sw_hold_reset: got %h required %h", obs, r_inrst());
      end
      rst = 1'b0;
   endtask

   task automatic test_rtype();
      logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b111, 3'b110};
      logic [2:0] alus[5] = '{3'd1,   3'd5,   3'd4,   3'd2,   3'd3};
      for (int k = 0; k < 5; k++) begin
         set_instr(7'b0110011, f3s[k], 1'b1, 1'b0);
         sbq.push_back(r_fetch());
         sbq.push_back(r_decode());
         sbq.push_back(rec(6, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, alus[k], 0));
         sbq.push_back(r_aluwb());
         for (int i = 0; sbq.size() != 0; i++) begin
            @(negedge clk);
            exp_r = sbq.pop_front();
            n_chk++;
            if (obs !== exp_r) begin
               n_fail++;
               $display("FAIL rtype f3=%b cyc%0d: got %h required %h", f3s[k], i, obs, exp_r);
            end
         end
      end
   endtask

   task automatic test_itype();
      logic [2:0] f3s [5] = '{3'b000, 3'b111, 3'b110, 3'b010, 3'b001};
      logic [2:0] alus[5] = '{3'd0,   3'd2,   3'd3,   3'd4,   3'd5};
      for (int k = 0; k < 5; k++) begin
         set_instr(7'b0010011, f3s[k], 1'b1, 1'b0);
         sbq.push_back(r_fetch());
         sbq.push_back(r_decode());
         sbq.push_back(rec(7, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, alus[k], 0));
         sbq.push_back(r_aluwb());
         for (int i = 0; sbq.size() != 0; i++) begin
            @(negedge clk);
            exp_r = sbq.pop_front();
            n_chk++;
            if (obs !== exp_r) begin
               n_fail++;
               $display("FAIL itype f3=%b cyc%0d: got %h required %h", f3s[k], i, obs, exp_r);
            end
         end
      end
   endtask

   task automatic test_branch();
      logic [2:0] f3s[4] = '{3'b000, 3'b000, 3'b001, 3'b001};
      logic       zs [4] = '{1'b1,   1'b0,   1'b0,   1'b1};
      logic       tk [4] = '{1'b1,   1'b0,   1'b1,   1'b0};
      for (int k = 0; k < 4; k++) begin
         set_instr(7'b1100011, f3s[k], 1'b0, zs[k]);
         sbq.push_back(r_fetch());
         sbq.push_back(r_decode());
         sbq.push_back(rec(9, tk[k],0,0,0,0, 2'b00, 2'b10, 2'b00, 3'd1, 0));
         for (int i = 0; sbq.size() != 0; i++) begin
            @(negedge clk);
            exp_r = sbq.pop_front();
            n_chk++;
            if (obs !== exp_r) begin
               n_fail++;
               $display("FAIL branch k%0d cyc%0d: got %h required %h", k, i, obs, exp_r);
            end
         end
      end
   endtask

   task automatic test_illegal();
      set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
      sbq.push_back(r_fetch());
      sbq.push_back(rec(1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'd0, 1));
      sbq.push_back(r_fetch());
      for (int i = 0; sbq.size() != 0; i++) begin
         @(negedge clk);
         exp_r = sbq.pop_front();
         n_chk++;
         if (obs !== exp_r) begin
            n_fail++;
            $display("FAIL illegal cyc%0d: got %h required %h", i, obs, exp_r);
         end
      end
      // The trailing FETCH above was the start of the next instruction; finish it as a jal.
      set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
      sbq.push_back(r_decode());
      sbq.push_back(rec(10, 1,0,0,0,0, 2'b00, 2'b01, 2'b10, 3'd0, 0));
      sbq.push_back(r_aluwb());
      for (int i = 0; sbq.size() != 0; i++) begin
         @(negedge clk);
         exp_r = sbq.pop_front();
         n_chk++;
         if (obs !== exp_r) begin
            n_fail++;
            $display("FAIL jal_after_illegal cyc%0d: got %h required %h", i, obs, exp_r);
         end
      end
   endtask

   task automatic test_jal();
      set_instr(7'b1101111, 3'b101, 1'b1, 1'b1);
      sbq.push_back(r_fetch());
      sbq.push_back(r_decode());
      sbq.push_back(rec(10, 1,0,0,0,0, 2'b00, 2'b01, 2'b10, 3'd0, 0));
      sbq.push_back(r_aluwb());
      for (int i = 0; sbq.size() != 0; i++) begin
         @(negedge clk);
         exp_r = sbq.pop_front();
         n_chk++;
         if (obs !== exp_r) begin
            n_fail++;
            $display("FAIL jal cyc%0d: got %h required %h", i, obs, exp_r);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_reset();
      test_rtype();
      test_itype();
      test_branch();
      test_illegal();
      test_jal();
      test_lw();
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle RISC-V control unit; the producer of the 3-bit ALU control code that the ALU consumes, and the consumer of the ALU zero flag.
- Moore FSM sequences fetch/decode/execute/memory/writeback; drives datapath mux selects, write enables and alu_ctrl every cycle.
- Supports lw, sw, R-type (add, sub, and, or, slt, sll), I-type ALU (addi, andi, ori, slti, slli), beq/bne, jal.

Parameters:
- STATE_WIDTH, 4, width of state register and state_o debug port

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- opcode_i  input  7  instr[6:0] from instruction register
- funct3_i  input  3  instr[14:12]
- funct7_5_i  input  1  instr[30]
- zero_i  input  1  ALU zero flag (1 when ALU result == 0)
- pc_write_o  output  1  PC register enable
- adr_src_o  output  1  memory address select: 0 = PC, 1 = ALU result register
- ir_write_o  output  1  instruction register / old-PC enable
- mem_write_o  output  1  data memory write enable
- reg_write_o  output  1  register file write enable
- result_src_o  output  2  00 = ALU result register, 01 = memory data, 10 = live ALU output
- alu_src_a_o  output  2  00 = PC, 01 = old PC, 10 = rs1 data
- alu_src_b_o  output  2  00 = rs2 data, 01 = immediate, 10 = constant 4
- alu_ctrl_o  output  3  0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 4 = SLT, 5 = LSHIFT
- illegal_o  output  1  one-cycle pulse in DECODE when the opcode is unsupported
- state_o  output  STATE_WIDTH  current state, for debug and verification

Behaviour:
- States and encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10.
- Reset: state goes to FETCH immediately (asynchronous).
  - While rst is high, pc_write_o, ir_write_o, mem_write_o, reg_write_o and illegal_o are forced to 0.
  - Mux selects and alu_ctrl_o show the FETCH values.
  - Asserting reset in mid-instruction abandons the instruction; no write enable asserts after reset assertion.
- Transitions:
  - FETCH -> DECODE always.
  - DECODE -> MEMADR for opcodes 0000011 and 0100011; EXECR for 0110011; EXECI for 0010011; BRANCH for 1100011; JAL for 1101111.
  - Any other opcode in DECODE: illegal_o = 1 and next state is FETCH.
  - MEMADR -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD -> MEMWB. EXECR and EXECI -> ALUWB. JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
- Cycle counts: lw 5, sw 4, R-type and I-type 4, branch 3, jal 4, illegal 2.
- Output decode (unlisted signals are 0 / 00):
  - FETCH: adr_src 0, ir_write 1, src_a 00, src_b 10, ALU ADD, result_src 10, pc_write 1.
  - DECODE: src_a 01, src_b 01, ALU ADD (computes branch target).
  - MEMADR: src_a 10, src_b 01, ADD.
  - MEMREAD: result_src 00, adr_src 1.
  - MEMWB: result_src 01, reg_write 1.
  - MEMWRITE: result_src 00, adr_src 1, mem_write 1.
  - EXECR: src_a 10, src_b 00, ALU from funct decode.
  - EXECI: src_a 10, src_b 01, ALU from funct decode.
  - ALUWB: result_src 00, reg_write 1.
  - BRANCH: src_a 10, src_b 00, SUB, result_src 00; pc_write = zero_i XOR funct3_i[0] (beq taken on zero, bne taken on nonzero).
  - JAL: src_a 01, src_b 10, ADD, result_src 00, pc_write 1.
- Funct decode (EXECR/EXECI only), keyed on funct3:
  - 000: SUB if EXECR and funct7_5 = 1, else ADD (addi ignores funct7_5).
  - 001: LSHIFT. 010: SLT. 110: OR. 111: AND.
  - Other funct3 values: ADD.
- pc_write_o in BRANCH is the only output that depends combinationally on an input; all other outputs are a function of state (and funct fields in EXECR/EXECI and DECODE).
- Opcode/funct inputs are sampled only in DECODE, MEMADR, EXECR, EXECI and BRANCH; they are held stable by the instruction register.

Test Plan:
- Reset mid-MEMWRITE: assert rst during a sw at state 5 -> state_o = 0 on the same cycle, mem_write_o = 0; after release, FETCH with ir_write_o = 1 and pc_write_o = 1.
- lw sequence, opcode 0000011: states 0,1,2,3,4 -> reg_write_o = 1 only in state 4 with result_src_o = 01; adr_src_o = 1 in state 3; back to state 0.
- R-type sub, opcode 0110011, funct3 000, funct7_5 = 1 -> alu_ctrl_o = 1 in EXECR. Repeat with funct3 001 -> 5, funct3 010 -> 4, funct3 111 -> 2, funct3 110 -> 3.
- addi with funct7_5 = 1, opcode 0010011, funct3 000 -> alu_ctrl_o = 0 in EXECI; src_b = 01.
- beq/bne, opcode 1100011:
  - funct3 000, zero_i = 1 -> pc_write_o = 1 in BRANCH.
  - funct3 000, zero_i = 0 -> pc_write_o = 0.
  - funct3 001, zero_i = 0 -> pc_write_o = 1.
  - All cases: 3 cycles total, then FETCH.
- Illegal opcode 1111111 in DECODE -> illegal_o pulses for 1 cycle, no write enable asserts, next state FETCH; jal 1101111 -> states 0,1,10,8 with pc_write_o = 1 in state 10 and reg_write_o = 1 in state 8.
